// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit
//
// MEM-stage load/store sequencer. Accepts one load or store from the pipeline, holds the pipeline
// while a single-beat request is outstanding on the memory port, positions store data and byte
// strobes by address offset, and right-aligns load data so the addressed byte lands at bit 0
// (sign/zero extension is done downstream). A request with no ack after TIMEOUT_CYCLES access
// cycles completes with a bus error.
//
// Optional feature macro: MISALIGN_CHECK_EN
//   defined   : misaligned LH/LHU/SH (addr[0]=1) and LW/SW (addr[1:0]!=0) skip the memory access
//               and complete with o_misaligned=1, o_rdata=0.
//   undefined : o_misaligned is always 0; halfword offset is {addr[1],0}, word offset is 0.
//
// Ports
//   clk           clock, all state on rising edge
//   i_rst_n       asynchronous active-low reset
//   i_valid       MEM-stage instruction valid
//   i_opcode      instruction opcode (load 0000011, store 0100011)
//   i_func3       access size / signedness
//   i_addr        effective byte address
//   i_wdata       store data (rs2)
//   o_stall       hold pipeline
//   o_mem_req     memory request, only while accessing
//   o_mem_addr    word-aligned address
//   o_mem_we      byte write strobes
//   o_mem_wdata   lane-replicated store data
//   i_mem_ack     memory completion
//   i_mem_rdata   memory read word, valid with ack
//   o_rdata       load word shifted so the addressed byte is at bit 0
//   o_done        one-cycle completion pulse
//   o_bus_err     one-cycle timeout flag (with o_done)
//   o_misaligned  one-cycle misalignment flag (with o_done)

module data_mem_access_unit #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   input  logic [6:0]            i_opcode,
   input  logic [2:0]            i_func3,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   output logic                  o_stall,
   output logic                  o_mem_req,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [3:0]            o_mem_we,
   output logic [DATA_WIDTH-1:0] o_mem_wdata,
   input  logic                  i_mem_ack,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata,
   output logic [DATA_WIDTH-1:0] o_rdata,
   output logic                  o_done,
   output logic                  o_bus_err,
   output logic                  o_misaligned
);

   localparam int unsigned LaneW       = DATA_WIDTH / 4;
   localparam logic [6:0]  OpLoad      = 7'b0000011;
   localparam logic [6:0]  OpStore     = 7'b0100011;
   localparam logic [7:0]  TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StResp
   } state_e;

   state_e                state_q, state_d;
   logic                  is_store_q, is_store_d;
   logic [1:0]            size_q, size_d;      // func3[1:0]: 00 byte, 01 half, 10 word
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  bus_err_q, bus_err_d;
   logic                  misal_q, misal_d;

   logic                  load_ok;
   logic                  store_ok;
   logic                  accept;
   logic                  req_misal;
   logic [1:0]            eff_off;
   logic [DATA_WIDTH-1:0] rdata_shifted;
   logic [3:0]            we_pos;
   logic [DATA_WIDTH-1:0] wdata_pos;

   // ---------------------------------------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------------------------------------
   // Legal loads: LB LH LW LBU LHU. Legal stores: SB SH SW.
   assign load_ok  = (i_opcode == OpLoad) && (i_func3 != 3'b011) && (i_func3 != 3'b110) &&
                     (i_func3 != 3'b111);
   assign store_ok = (i_opcode == OpStore) && !i_func3[2] && (i_func3[1:0] != 2'b11);

   // Gated by reset so o_stall reads 0 while reset is held.
   assign accept = i_rst_n && (state_q == StIdle) && i_valid && (load_ok || store_ok);

`ifdef MISALIGN_CHECK_EN
   assign req_misal = ((i_func3[1:0] == 2'b01) && i_addr[0]) ||
                      ((i_func3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
`else
   assign req_misal = 1'b0;
`endif

   // ---------------------------------------------------------------------------------------------
   // Lane positioning from the registered request
   // ---------------------------------------------------------------------------------------------
   // Halfwords are forced onto an even lane pair and words onto lane 0, so an unchecked
   // misaligned access simply uses the enclosing aligned location.
   always_comb begin
      eff_off = 2'b00;
      unique case (size_q)
         2'b00:   eff_off = addr_q[1:0];
         2'b01:   eff_off = {addr_q[1], 1'b0};
         default: eff_off = 2'b00;
      endcase
   end

   always_comb begin
      we_pos    = 4'b0000;
      wdata_pos = wdata_q;
      unique case (size_q)
         2'b00: begin
            we_pos    = 4'b0001 << eff_off;
            wdata_pos = {4{wdata_q[LaneW-1:0]}};
         end
         2'b01: begin
            we_pos    = 4'b0011 << eff_off;
            wdata_pos = {2{wdata_q[2*LaneW-1:0]}};
         end
         default: begin
            we_pos    = 4'b1111;
            wdata_pos = wdata_q;
         end
      endcase
   end

   // Zero-filled right shift; the addressed byte lands at bit 0.
   assign rdata_shifted = i_mem_rdata >> (LaneW * 32'(eff_off));

   // ---------------------------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      is_store_d = is_store_q;
      size_d     = size_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      cnt_d      = cnt_q;
      bus_err_d  = bus_err_q;
      misal_d    = misal_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               is_store_d = store_ok;
               size_d     = i_func3[1:0];
               addr_d     = i_addr;
               wdata_d    = i_wdata;
               cnt_d      = 8'd0;
               bus_err_d  = 1'b0;
               misal_d    = req_misal;
               if (req_misal) begin
                  rdata_d = '0;
                  state_d = StResp;
               end else begin
                  state_d = StAccess;
               end
            end
         end

         StAccess: begin
            // Ack is checked first so an ack on the final allowed cycle still completes normally.
            if (i_mem_ack) begin
               if (!is_store_q) begin
                  rdata_d = rdata_shifted;
               end
               state_d = StResp;
            end else if (cnt_q == TimeoutLast) begin
               rdata_d   = '0;
               bus_err_d = 1'b1;
               state_d   = StResp;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         StResp: begin
            // No acceptance here: the completed instruction is still on the inputs and leaves
            // at the end of this cycle.
            cnt_d   = 8'd0;
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= StIdle;
         is_store_q <= 1'b0;
         size_q     <= 2'b00;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         cnt_q      <= 8'd0;
         bus_err_q  <= 1'b0;
         misal_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         is_store_q <= is_store_d;
         size_q     <= size_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         cnt_q      <= cnt_d;
         bus_err_q  <= bus_err_d;
         misal_q    <= misal_d;
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------------------------
   // Memory-port outputs are gated by the access state so they read 0 whenever no request is
   // outstanding, including the instant reset asserts.
   always_comb begin
      o_stall      = accept || (state_q == StAccess);
      o_mem_req    = (state_q == StAccess);
      o_mem_addr   = '0;
      o_mem_we     = 4'b0000;
      o_mem_wdata  = '0;
      if (state_q == StAccess) begin
         o_mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
         o_mem_we    = is_store_q ? we_pos : 4'b0000;
         o_mem_wdata = wdata_pos;
      end
      o_rdata      = rdata_q;
      o_done       = (state_q == StResp);
      o_bus_err    = (state_q == StResp) && bus_err_q;
      o_misaligned = (state_q == StResp) && misal_q;
   end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Testbench for data_mem_access_unit (TIMEOUT_CYCLES = 4). Expected results come from a
// byte-level reference model of loads/stores; honours MISALIGN_CHECK_EN when defined.

module tb_data_mem_access_unit;

   localparam int T = 4;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;

   logic        clk = 1'b0;
   logic        i_rst_n;
   logic        i_valid;
   logic [6:0]  i_opcode;
   logic [2:0]  i_func3;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic        o_stall;
   logic        o_mem_req;
   logic [31:0] o_mem_addr;
   logic [3:0]  o_mem_we;
   logic [31:0] o_mem_wdata;
   logic        i_mem_ack;
   logic [31:0] i_mem_rdata;
   logic [31:0] o_rdata;
   logic        o_done;
   logic        o_bus_err;
   logic        o_misaligned;

   int checks = 0;
   int errors = 0;
   logic [31:0] model_rdata = 32'h0;

   always #5 clk = ~clk;

   data_mem_access_unit #(
      .DATA_WIDTH    (32),
      .ADDR_WIDTH    (32),
      .TIMEOUT_CYCLES(T)
   ) dut (
      .clk         (clk),
      .i_rst_n     (i_rst_n),
      .i_valid     (i_valid),
      .i_opcode    (i_opcode),
      .i_func3     (i_func3),
      .i_addr      (i_addr),
      .i_wdata     (i_wdata),
      .o_stall     (o_stall),
      .o_mem_req   (o_mem_req),
      .o_mem_addr  (o_mem_addr),
      .o_mem_we    (o_mem_we),
      .o_mem_wdata (o_mem_wdata),
      .i_mem_ack   (i_mem_ack),
      .i_mem_rdata (i_mem_rdata),
      .o_rdata     (o_rdata),
      .o_done      (o_done),
      .o_bus_err   (o_bus_err),
      .o_misaligned(o_misaligned)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  we;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          done_cyc;
      int          nreq;
      logic        err;
      logic        mis;
   } exp_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  we;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          done_cyc;
      int          nreq;
      logic        err;
      logic        mis;
      int          stall_cnt;
      logic        unstable;
   } obs_t;

   // Reference model: access of 2**f3[1:0] bytes at a byte address; memory is word organised.
   function automatic exp_t model_txn(input logic [2:0] f3, input logic is_store,
                                      input logic [31:0] addr, input logic [31:0] wd,
                                      input int dly, input logic [31:0] rd,
                                      input logic [31:0] prev);
      exp_t e;
      int   nbytes;
      int   off;
      e      = '0;
      nbytes = 1 << f3[1:0];
      off    = int'(addr % 32'd4);
      if (nbytes == 2) off = off - (off % 2);
      if (nbytes == 4) off = 0;
      e.addr  = addr - (addr % 32'd4);
      e.we    = is_store ? 4'(((1 << nbytes) - 1) << off) : 4'b0000;
      e.wdata = (nbytes == 1) ? {24'h0, wd[7:0]} * 32'h0101_0101 :
                (nbytes == 2) ? {16'h0, wd[15:0]} * 32'h0001_0001 : wd;
      e.mis   = 1'b0;
`ifdef MISALIGN_CHECK_EN
      e.mis   = (addr % 32'(nbytes)) != 32'd0;
`endif
      if (e.mis) begin
         e.nreq = 0; e.done_cyc = 1; e.err = 1'b0; e.rdata = 32'h0;
      end else if (dly >= 0 && dly < T) begin
         e.nreq = dly + 1; e.done_cyc = dly + 2; e.err = 1'b0;
         e.rdata = is_store ? prev : (rd >> (8 * off));
      end else begin
         e.nreq = T; e.done_cyc = T + 1; e.err = 1'b1; e.rdata = 32'h0;
      end
      return e;
   endfunction

   // Presents one instruction and plays the memory: ack on the dly-th request cycle (0 = first),
   // never if dly < 0. Inputs change #1 after posedge; outputs are sampled at negedge.
   task automatic run_txn(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int dly, input logic [31:0] rd,
                          output obs_t o);
      int nreq;
      o = '0;
      o.done_cyc = -1;
      nreq = 0;
      @(posedge clk); #1;
      i_valid = 1'b1; i_opcode = op; i_func3 = f3; i_addr = addr; i_wdata = wd;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (o_stall) o.stall_cnt++;
         i_mem_ack = 1'b0;
         if (o_mem_req) begin
            if (nreq == 0) begin
               o.addr = o_mem_addr; o.we = o_mem_we; o.wdata = o_mem_wdata;
            end else if (o.addr !== o_mem_addr || o.we !== o_mem_we || o.wdata !== o_mem_wdata) begin
               o.unstable = 1'b1;
            end
            if (nreq == dly) begin
               i_mem_ack = 1'b1; i_mem_rdata = rd;
            end
            nreq++;
         end
         if (o_done) begin
            o.done_cyc = cyc; o.err = o_bus_err; o.mis = o_misaligned; o.rdata = o_rdata;
            break;
         end
      end
      o.nreq = nreq;
      @(posedge clk); #1;
      i_valid = 1'b0; i_mem_ack = 1'b0; i_mem_rdata = $urandom;
   endtask

   task automatic test_reset;
      i_rst_n = 1'b0; i_valid = 1'b1; i_opcode = OP_LD; i_func3 = 3'b010;
      i_addr = 32'h100; i_wdata = 32'h1; i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFF_FFFF;
      repeat (3) @(negedge clk);
      checks++;
      if ({o_stall, o_mem_req, o_done, o_bus_err, o_misaligned} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got stall/req/done/err/mis=%b required 00000",
                  {o_stall, o_mem_req, o_done, o_bus_err, o_misaligned});
      end
      checks++;
      if ({o_mem_addr, o_mem_we, o_mem_wdata, o_rdata} !== 100'b0) begin
         errors++;
         $display("FAIL reset_data: got addr=%h we=%b wdata=%h rdata=%h required all zero",
                  o_mem_addr, o_mem_we, o_mem_wdata, o_rdata);
      end
      i_rst_n = 1'b1; i_valid = 1'b0; i_mem_ack = 1'b0;
      model_rdata = 32'h0;
   endtask

   typedef struct packed {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      int          dly;
      logic [31:0] rd;
      exp_t        e;
   } dcase_t;

   task automatic test_directed;
      dcase_t tbl[7];
      obs_t   o;
      tbl[0] = '{OP_LD, 3'b010, 32'h100, 32'h0, 0, 32'hDEAD_BEEF,
                 '{32'h100, 4'b0000, 32'h0, 32'hDEAD_BEEF, 2, 1, 1'b0, 1'b0}};
      tbl[1] = '{OP_ST, 3'b000, 32'h203, 32'h0000_00A5, 0, 32'h0,
                 '{32'h200, 4'b1000, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 2, 1, 1'b0, 1'b0}};
      tbl[2] = '{OP_LD, 3'b100, 32'h102, 32'h0, 0, 32'h1122_3344,
                 '{32'h100, 4'b0000, 32'h0, 32'h0000_1122, 2, 1, 1'b0, 1'b0}};
      tbl[3] = '{OP_LD, 3'b010, 32'h100, 32'h0, -1, 32'h0,
                 '{32'h100, 4'b0000, 32'h0, 32'h0, 5, 4, 1'b1, 1'b0}};
      tbl[4] = '{OP_LD, 3'b010, 32'h104, 32'h0, 3, 32'hCAFE_F00D,
                 '{32'h104, 4'b0000, 32'h0, 32'hCAFE_F00D, 5, 4, 1'b0, 1'b0}};
`ifdef MISALIGN_CHECK_EN
      tbl[5] = '{OP_LD, 3'b001, 32'h101, 32'h0, 0, 32'h8765_ABCD,
                 '{32'h0, 4'b0000, 32'h0, 32'h0, 1, 0, 1'b0, 1'b1}};
      tbl[6] = '{OP_ST, 3'b001, 32'h206, 32'h1234_BEEF, 1, 32'h0,
                 '{32'h204, 4'b1100, 32'hBEEF_BEEF, 32'h0, 3, 2, 1'b0, 1'b0}};
`else
      tbl[5] = '{OP_LD, 3'b001, 32'h101, 32'h0, 0, 32'h8765_ABCD,
                 '{32'h100, 4'b0000, 32'h0, 32'h8765_ABCD, 2, 1, 1'b0, 1'b0}};
      tbl[6] = '{OP_ST, 3'b001, 32'h206, 32'h1234_BEEF, 1, 32'h0,
                 '{32'h204, 4'b1100, 32'hBEEF_BEEF, 32'h8765_ABCD, 3, 2, 1'b0, 1'b0}};
`endif
      foreach (tbl[i]) begin
         run_txn(tbl[i].op, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].dly, tbl[i].rd, o);
         checks++;
         if (o.done_cyc !== tbl[i].e.done_cyc || o.stall_cnt !== tbl[i].e.done_cyc) begin
            errors++;
            $display("FAIL dir%0d_timing: got done@%0d stall=%0d required done@%0d stall=%0d", i,
                     o.done_cyc, o.stall_cnt, tbl[i].e.done_cyc, tbl[i].e.done_cyc);
         end
         checks++;
         if (o.nreq !== tbl[i].e.nreq || o.err !== tbl[i].e.err || o.mis !== tbl[i].e.mis) begin
            errors++;
            $display("FAIL dir%0d_flags: got nreq=%0d err=%b mis=%b required %0d %b %b", i,
                     o.nreq, o.err, o.mis, tbl[i].e.nreq, tbl[i].e.err, tbl[i].e.mis);
         end
         checks++;
         if (o.rdata !== tbl[i].e.rdata) begin
            errors++;
            $display("FAIL dir%0d_rdata: got %h required %h", i, o.rdata, tbl[i].e.rdata);
         end
         if (tbl[i].e.nreq > 0) begin
            checks++;
            if (o.addr !== tbl[i].e.addr || o.we !== tbl[i].e.we || o.unstable !== 1'b0) begin
               errors++;
               $display("FAIL dir%0d_port: got addr=%h we=%b unstable=%b required %h %b 0", i,
                        o.addr, o.we, o.unstable, tbl[i].e.addr, tbl[i].e.we);
            end
            if (tbl[i].op == OP_ST) begin
               checks++;
               if (o.wdata !== tbl[i].e.wdata) begin
                  errors++;
                  $display("FAIL dir%0d_wdata: got %h required %h", i, o.wdata, tbl[i].e.wdata);
               end
            end
         end
      end
      model_rdata = tbl[6].e.rdata;
   endtask

   task automatic test_random;
      logic [2:0]  ld_f3[5];
      logic [2:0]  st_f3[3];
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [31:0] addr, wd, rd;
      int          dly;
      exp_t        e;
      obs_t        o;
      ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      st_f3 = '{3'b000, 3'b001, 3'b010};
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 1) == 0) begin
            op = OP_LD; f3 = ld_f3[$urandom_range(0, 4)];
         end else begin
            op = OP_ST; f3 = st_f3[$urandom_range(0, 2)];
         end
         addr = $urandom; wd = $urandom; rd = $urandom;
         dly  = int'($urandom_range(0, 6)) - 1;
         e = model_txn(f3, op == OP_ST, addr, wd, dly, rd, model_rdata);
         run_txn(op, f3, addr, wd, dly, rd, o);
         model_rdata = e.rdata;
         checks++;
         if (o.done_cyc !== e.done_cyc || o.stall_cnt !== e.done_cyc || o.nreq !== e.nreq ||
             o.err !== e.err || o.mis !== e.mis) begin
            errors++;
            $display("FAIL rnd%0d_ctrl: got done@%0d stall=%0d nreq=%0d err=%b mis=%b required %0d %0d %0d %b %b",
                     n, o.done_cyc, o.stall_cnt, o.nreq, o.err, o.mis, e.done_cyc, e.done_cyc,
                     e.nreq, e.err, e.mis);
         end
         checks++;
         if (o.rdata !== e.rdata) begin
            errors++;
            $display("FAIL rnd%0d_rdata: got %h required %h", n, o.rdata, e.rdata);
         end
         if (e.nreq > 0) begin
            checks++;
            if (o.addr !== e.addr || o.we !== e.we || o.unstable !== 1'b0 ||
                (op == OP_ST && o.wdata !== e.wdata)) begin
               errors++;
               $display("FAIL rnd%0d_port: got addr=%h we=%b wdata=%h unstable=%b required %h %b %h 0",
                        n, o.addr, o.we, o.wdata, o.unstable, e.addr, e.we, e.wdata);
            end
         end
      end
   endtask

   task automatic test_ignored;
      logic [2:0] bad_ld[3];
      bad_ld = '{3'b011, 3'b110, 3'b111};
      for (int n = 0; n < 24; n++) begin
         @(posedge clk); #1;
         i_valid = 1'b1; i_addr = $urandom; i_wdata = $urandom;
         i_mem_ack = 1'($urandom_range(0, 1));
         unique case (n % 4)
            0: begin i_opcode = OP_LD; i_func3 = bad_ld[$urandom_range(0, 2)]; end
            1: begin i_opcode = OP_ST; i_func3 = 3'($urandom_range(3, 7)); end
            2: begin i_opcode = 7'b0110011; i_func3 = 3'($urandom); end
            default: begin i_valid = 1'b0; i_opcode = OP_LD; i_func3 = 3'b010; end
         endcase
         @(negedge clk);
         checks++;
         if ({o_stall, o_mem_req, o_done} !== 3'b000 || o_rdata !== model_rdata) begin
            errors++;
            $display("FAIL ignored%0d: got stall/req/done=%b rdata=%h required 000 %h", n,
                     {o_stall, o_mem_req, o_done}, o_rdata, model_rdata);
         end
      end
      @(posedge clk); #1;
      i_valid = 1'b0; i_mem_ack = 1'b0;
   endtask

   task automatic test_reset_mid_access;
      obs_t o;
      exp_t e;
      @(posedge clk); #1;
      i_valid = 1'b1; i_opcode = OP_LD; i_func3 = 3'b010; i_addr = 32'h300; i_mem_ack = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (o_mem_req !== 1'b1 || o_stall !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_pre: got req=%b stall=%b required 1 1", o_mem_req, o_stall);
      end
      #2 i_rst_n = 1'b0;
      #1;
      checks++;
      if ({o_mem_req, o_stall, o_done, o_mem_addr} !== 35'b0) begin
         errors++;
         $display("FAIL rstmid_async: got req=%b stall=%b done=%b addr=%h required all zero",
                  o_mem_req, o_stall, o_done, o_mem_addr);
      end
      i_valid = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h5555_AAAA;
      @(negedge clk);
      i_rst_n = 1'b1;
      model_rdata = 32'h0;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         checks++;
         if ({o_mem_req, o_stall, o_done} !== 3'b000 || o_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_ack_ignored%0d: got req/stall/done=%b rdata=%h required 000 0", n,
                     {o_mem_req, o_stall, o_done}, o_rdata);
         end
      end
      i_mem_ack = 1'b0;
      e = model_txn(3'b000, 1'b0, 32'h301, 32'h0, 0, 32'h1234_5678, model_rdata);
      run_txn(OP_LD, 3'b000, 32'h301, 32'h0, 0, 32'h1234_5678, o);
      model_rdata = e.rdata;
      checks++;
      if (o.done_cyc !== e.done_cyc || o.rdata !== e.rdata || o.addr !== e.addr) begin
         errors++;
         $display("FAIL rstmid_resume: got done@%0d rdata=%h addr=%h required %0d %h %h",
                  o.done_cyc, o.rdata, o.addr, e.done_cyc, e.rdata, e.addr);
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_random;
      test_ignored;
      test_reset_mid_access;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, required completion before 200000");
      $fatal(1);
   end

endmodule
